// File: rtl/seq_gen_pkg.sv
// Shared types and digit helpers for the memory-game sequence generator.
package seq_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Helper widths are sized for the largest supported sequence; callers
  // zero-extend their packed sequence and truncate the returned digit.
  localparam int unsigned SEQ_MAX_W = 256;
  localparam int unsigned DIG_MAX_W = 32;

  function automatic logic [DIG_MAX_W-1:0] get_digit(
    input logic [SEQ_MAX_W-1:0] s,
    input int unsigned          idx,
    input int unsigned          w
  );
    logic [SEQ_MAX_W-1:0] sh;
    logic [DIG_MAX_W-1:0] mask;
    sh   = s >> (idx * w);
    mask = {DIG_MAX_W{1'b1}} >> (DIG_MAX_W - w);
    return DIG_MAX_W'(sh) & mask;
  endfunction

  // Bumps a digit that would repeat its predecessor, wrapping within w bits.
  function automatic logic [DIG_MAX_W-1:0] no_repeat_adjust(
    input logic [DIG_MAX_W-1:0] cur,
    input logic [DIG_MAX_W-1:0] prev,
    input int unsigned          w
  );
    logic [DIG_MAX_W-1:0] mask;
    mask = {DIG_MAX_W{1'b1}} >> (DIG_MAX_W - w);
    if (cur == prev) return (cur + DIG_MAX_W'(1)) & mask;
    return cur;
  endfunction

endpackage

// File: rtl/seq_gen_ctrl.sv
// Memory-game sequence generator: loads/extends the target sequence and times its display.
// Optional feature: define SEQ_GEN_NO_REPEAT_EN to forbid a digit equal to its predecessor.
module seq_gen_ctrl
  import seq_gen_pkg::*;
#(
  parameter int DIGIT_W  = 4,
  parameter int MAX_LEN  = 5,
  parameter int INIT_LEN = 1,
  parameter int DISP_CYC = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       b_seq,
  input  logic                       b_next,
  input  logic [DIGIT_W*MAX_LEN-1:0] in_rand_num,
  output logic [DIGIT_W*MAX_LEN-1:0] seq,
  output logic [LEN_W-1:0]           seq_len,
  output logic                       display,
  output logic                       new_seq,
  output logic                       seq_ext,
  output logic                       full,
  output logic                       busy
);

  localparam int SEQ_W = DIGIT_W * MAX_LEN;
  localparam int CNT_W = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;

`ifdef SEQ_GEN_NO_REPEAT_EN
  localparam bit NO_REPEAT = 1'b1;
`else
  localparam bit NO_REPEAT = 1'b0;
`endif

  function automatic logic [DIGIT_W-1:0] digit_of(input logic [SEQ_W-1:0] s, input int i);
    return DIGIT_W'(get_digit(SEQ_MAX_W'(s), i, DIGIT_W));
  endfunction

  function automatic logic [DIGIT_W-1:0] adjust(input logic [DIGIT_W-1:0] cur,
                                                input logic [DIGIT_W-1:0] prev);
    return DIGIT_W'(no_repeat_adjust(DIG_MAX_W'(cur), DIG_MAX_W'(prev), DIGIT_W));
  endfunction

  state_t             state_q, state_d;
  logic               b_seq_q, b_next_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEQ_W-1:0]   seq_d;
  logic [LEN_W-1:0]   seq_len_d;
  logic               full_d, new_seq_d, seq_ext_d;
  logic               do_load, do_append;
  logic [DIGIT_W-1:0] dig, prev;

  // Rises arriving while SHOW is active are simply dropped, never queued.
  assign do_load   = (state_q == IDLE) && b_seq && !b_seq_q;
  assign do_append = (state_q == IDLE) && !(b_seq && !b_seq_q) && b_next && !b_next_q && !full;

  assign display = (state_q == SHOW);
  assign busy    = (state_q == SHOW);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      b_seq_q  <= 1'b0;
      b_next_q <= 1'b0;
      cnt_q    <= '0;
      seq      <= '0;
      seq_len  <= '0;
      full     <= 1'b0;
      new_seq  <= 1'b0;
      seq_ext  <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_seq_q  <= b_seq;
      b_next_q <= b_next;
      cnt_q    <= cnt_d;
      seq      <= seq_d;
      seq_len  <= seq_len_d;
      full     <= full_d;
      new_seq  <= new_seq_d;
      seq_ext  <= seq_ext_d;
    end
  end

  // NOTE: each combinational block assigns every output a default first, so
  // no path can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_load || do_append) state_d = SHOW;
      SHOW:    if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    seq_d     = seq;
    seq_len_d = seq_len;
    full_d    = full;
    new_seq_d = 1'b0;
    seq_ext_d = 1'b0;
    cnt_d     = cnt_q;
    dig       = '0;
    prev      = '0;
    if (state_q == SHOW) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end else if (do_load) begin
      seq_d = '0;
      // The no-repeat chain resolves in index order against already-adjusted digits.
      for (int i = 0; i < INIT_LEN; i++) begin
        dig = digit_of(in_rand_num, i);
        if (NO_REPEAT && i > 0) dig = adjust(dig, prev);
        seq_d[i*DIGIT_W +: DIGIT_W] = dig;
        prev = dig;
      end
      seq_len_d = LEN_W'(INIT_LEN);
      full_d    = (INIT_LEN == MAX_LEN);
      new_seq_d = 1'b1;
      cnt_d     = CNT_W'(DISP_CYC - 1);
    end else if (do_append) begin
      dig = in_rand_num[DIGIT_W-1:0];
      for (int i = 0; i < MAX_LEN; i++)
        if (LEN_W'(i + 1) == seq_len) prev = digit_of(seq, i);
      if (NO_REPEAT && seq_len != '0) dig = adjust(dig, prev);
      for (int i = 0; i < MAX_LEN; i++)
        if (LEN_W'(i) == seq_len) seq_d[i*DIGIT_W +: DIGIT_W] = dig;
      seq_len_d = seq_len + 1'b1;
      full_d    = (seq_len_d == LEN_W'(MAX_LEN));
      seq_ext_d = 1'b1;
      cnt_d     = CNT_W'(DISP_CYC - 1);
    end
  end

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// Directed self-checking bench for seq_gen_ctrl (DIGIT_W=4, MAX_LEN=5, INIT_LEN=1, DISP_CYC=8).
module tb_seq_gen_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        b_seq, b_next;
  logic [19:0] in_rand_num;
  logic [19:0] seq;
  logic [2:0]  seq_len;
  logic        display, new_seq, seq_ext, full, busy;

  int errors = 0;
  int checks = 0;
  int n_disp, n_busy, n_ns, n_se;

  always #5 clk = ~clk;

  seq_gen_ctrl #(.DIGIT_W(4), .MAX_LEN(5), .INIT_LEN(1), .DISP_CYC(8)) dut (
    .clk(clk), .rst(rst), .b_seq(b_seq), .b_next(b_next), .in_rand_num(in_rand_num),
    .seq(seq), .seq_len(seq_len), .display(display), .new_seq(new_seq),
    .seq_ext(seq_ext), .full(full), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Counts high samples of the handshake outputs over a fixed window of negedges.
  task automatic watch(input int n, output int d, output int b, output int ns, output int se);
    d = 0; b = 0; ns = 0; se = 0;
    for (int k = 0; k < n; k++) begin
      d  += int'(display);
      b  += int'(busy);
      ns += int'(new_seq);
      se += int'(seq_ext);
      step();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_seq"}, 32'(seq), 32'h0);
    chk({tag, "_len"}, 32'(seq_len), 32'h0);
    chk({tag, "_ctl"}, {27'h0, display, new_seq, seq_ext, full, busy}, 32'h0);
  endtask

  initial begin
    logic [3:0] nibs [4];
    logic [19:0] exp_seq;
    nibs[0] = 4'h3; nibs[1] = 4'h7; nibs[2] = 4'h1; nibs[3] = 4'h9;

    rst = 1'b1; b_seq = 1'b0; b_next = 1'b0; in_rand_num = '0;
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // New game: only digit 0 survives, 8-cycle show
    in_rand_num = 20'hABCDE; b_seq = 1'b1;
    step();
    b_seq = 1'b0;
    chk("new_seq_val", 32'(seq), 32'h0000E);
    chk("new_len", 32'(seq_len), 32'd1);
    chk("new_pulse", {29'h0, new_seq, seq_ext, full}, 32'b100);
    watch(12, n_disp, n_busy, n_ns, n_se);
    chk("new_disp_cyc", n_disp, 8);
    chk("new_busy_cyc", n_busy, 8);
    chk("new_ns_cnt", n_ns, 1);
    chk("new_se_cnt", n_se, 0);

    // Four extensions to full
    exp_seq = 20'h0000E;
    for (int p = 0; p < 4; p++) begin
      in_rand_num = 20'hFFFF0 | 20'(nibs[p]); b_next = 1'b1;
      step();
      b_next = 1'b0;
      exp_seq[(p+1)*4 +: 4] = nibs[p];
      chk("ext_seq", 32'(seq), 32'(exp_seq));
      chk("ext_len", 32'(seq_len), 32'(p + 2));
      watch(12, n_disp, n_busy, n_ns, n_se);
      chk("ext_disp_cyc", n_disp, 8);
      chk("ext_pulses", {n_se[15:0], n_ns[15:0]}, {16'd1, 16'd0});
    end
    chk("full_seq", 32'(seq), 32'h9173E);
    chk("full_flag", 32'(full), 32'd1);

    // Press when full is ignored
    in_rand_num = 20'h00002; b_next = 1'b1;
    step();
    b_next = 1'b0;
    chk("full_ign_seq", 32'(seq), 32'h9173E);
    chk("full_ign_ctl", {29'h0, display, seq_ext, busy}, 32'h0);
    watch(10, n_disp, n_busy, n_ns, n_se);
    chk("full_ign_win", n_disp + n_se + n_ns, 0);

    // Simultaneous rise: new game wins; b_seq held through SHOW
    in_rand_num = 20'h12345; b_seq = 1'b1; b_next = 1'b1;
    step();
    b_next = 1'b0;
    chk("prio_seq", 32'(seq), 32'h00005);
    chk("prio_pulse", {29'h0, new_seq, seq_ext, full}, 32'b100);
    chk("prio_len", 32'(seq_len), 32'd1);
    watch(14, n_disp, n_busy, n_ns, n_se);
    chk("hold_ns_cnt", n_ns, 1);
    chk("hold_se_cnt", n_se, 0);
    chk("hold_disp_cyc", n_disp, 8);
    in_rand_num = 20'h00006;
    step();
    chk("hold_no_reload", 32'(seq), 32'h00005);
    b_seq = 1'b0;
    step();
    b_seq = 1'b1;
    step();
    b_seq = 1'b0;
    chk("repress_seq", 32'(seq), 32'h00006);
    chk("repress_ns", 32'(new_seq), 32'd1);

    // A b_next rise during SHOW is discarded
    step();
    b_next = 1'b1;
    step();
    b_next = 1'b0;
    watch(10, n_disp, n_busy, n_ns, n_se);
    chk("show_drop_se", n_se, 0);
    chk("show_drop_len", 32'(seq_len), 32'd1);
    chk("show_drop_disp", 32'(display), 32'd0);

    // Reset mid-SHOW clears immediately without a clock edge
    in_rand_num = 20'hABCDE; b_seq = 1'b1;
    step();
    b_seq = 1'b0;
    step();
    step();
    chk("pre_rst_disp", 32'(display), 32'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_mid_show");
    step();
    rst = 1'b0;
    step();

    // Repeated digit on append
    in_rand_num = 20'h0000E; b_seq = 1'b1;
    step();
    b_seq = 1'b0;
    watch(10, n_disp, n_busy, n_ns, n_se);
    b_next = 1'b1;
    step();
    b_next = 1'b0;
`ifdef SEQ_GEN_NO_REPEAT_EN
    chk("repeat_digit", 32'(seq), 32'h000FE);
`else
    chk("repeat_digit", 32'(seq), 32'h000EE);
`endif
    chk("repeat_len", 32'(seq_len), 32'd2);
    watch(10, n_disp, n_busy, n_ns, n_se);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
